// File: rtl/n16_butterfly_base_n4_top.sv
// Streaming 16-point complex FFT: two radix-4 stages (DIF), ping-pong input
// and output stores, natural-order output with a fixed 4-cycle latency.
module n16_butterfly_base_n4_top #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned Wn_WIDTH   = 8,
    parameter int unsigned N_POINT    = 16
) (
    input  logic                                        sys_clk_i,
    input  logic                                        rst_n_i,
    input  logic                                        data_in_valid_i,
    input  logic signed [DATA_WIDTH-1:0]                xn_real_i,
    input  logic signed [DATA_WIDTH-1:0]                xn_imag_i,
    output logic                                        data_out_valid_o,
    output logic signed [DATA_WIDTH+Wn_WIDTH+1:0]       xk_real_o,
    output logic signed [DATA_WIDTH+Wn_WIDTH+1:0]       xk_imag_o
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned WW = Wn_WIDTH;
    localparam int unsigned IW = $clog2(N_POINT);
    localparam int unsigned NP = 16;
    localparam int unsigned OW = DW + WW + 2;
    // Stage-1 sum of four (negated) samples, stage-1 product, stage-2 sum.
    localparam int unsigned YW = DW + 3;
    localparam int unsigned ZW = DW + WW + 3;
    localparam int unsigned XW = DW + WW + 5;

    // cos(pi/8), sin(pi/8), cos(pi/4) in Q30, rounded to WW-2 fraction bits below.
    localparam longint unsigned C1_Q30 = 64'd992008095;
    localparam longint unsigned S1_Q30 = 64'd410903207;
    localparam longint unsigned H_Q30  = 64'd759250125;

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    function automatic logic signed [WW-1:0] q_tw(input longint unsigned c);
        longint unsigned t;
        t = ((c << (WW - 2)) + 64'd536870912) >> 30;
        return WW'(t);
    endfunction

    localparam logic signed [WW-1:0] TW_ONE = WW'(64'd1 << (WW - 2));

    // W16^m = tw_cos(m) - j*tw_sin(m); only exponents n2*k1 in {0,1,2,3,4,6,9} occur.
    function automatic logic signed [WW-1:0] tw_cos(input logic [3:0] m);
        case (m)
            4'd0:    return TW_ONE;
            4'd1:    return q_tw(C1_Q30);
            4'd2:    return q_tw(H_Q30);
            4'd3:    return q_tw(S1_Q30);
            4'd6:    return -q_tw(H_Q30);
            4'd9:    return -q_tw(C1_Q30);
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [WW-1:0] tw_sin(input logic [3:0] m);
        case (m)
            4'd1:    return q_tw(S1_Q30);
            4'd2:    return q_tw(H_Q30);
            4'd3:    return q_tw(C1_Q30);
            4'd4:    return TW_ONE;
            4'd6:    return q_tw(H_Q30);
            4'd9:    return -q_tw(S1_Q30);
            default: return '0;
        endcase
    endfunction

    logic [IW-1:0]          wr_cnt;
    logic                   wr_bank;
    logic                   s1_bank;
    logic                   go1, go2, go3, go4;
    logic                   ob_wr;
    logic                   bank3, bank4;
    logic                   rd_bank;
    logic [IW-1:0]          rd_idx;
    state_t                 state;
    logic                   frame_done_c;

    logic signed [DW-1:0]   ibuf_re [2][NP];
    logic signed [DW-1:0]   ibuf_im [2][NP];
    logic signed [ZW-1:0]   z_re    [NP];
    logic signed [ZW-1:0]   z_im    [NP];
    logic signed [ZW-1:0]   z_re_c  [NP];
    logic signed [ZW-1:0]   z_im_c  [NP];
    logic signed [OW-1:0]   x_re_c  [NP];
    logic signed [OW-1:0]   x_im_c  [NP];
    logic signed [OW-1:0]   obuf_re [2][NP];
    logic signed [OW-1:0]   obuf_im [2][NP];

    logic signed [YW-1:0]   ya_re, ya_im, xa, xb;
    logic signed [WW-1:0]   twc, tws;
    logic signed [XW-1:0]   xacc_re, xacc_im, za, zb;

    assign frame_done_c = data_in_valid_i && (wr_cnt == IW'(NP - 1));

    // Sample counter, bank select and the 4-deep frame-event pipeline.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            s1_bank <= 1'b0;
            go1     <= 1'b0;
            go2     <= 1'b0;
            go3     <= 1'b0;
            go4     <= 1'b0;
            ob_wr   <= 1'b0;
            bank3   <= 1'b0;
            bank4   <= 1'b0;
        end else begin
            if (data_in_valid_i) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (frame_done_c) begin
                wr_bank <= ~wr_bank;
                s1_bank <= wr_bank;
            end
            go1 <= frame_done_c;
            go2 <= go1;
            go3 <= go2;
            go4 <= go3;
            if (go2) begin
                ob_wr <= ~ob_wr;
            end
            bank3 <= ob_wr;
            bank4 <= bank3;
        end
    end

    // Stage 1: radix-4 butterfly over x[n2+4*n1] for each n2, then twiddle W16^(n2*k1).
    always_comb begin
        z_re_c = '{default: '0};
        z_im_c = '{default: '0};
        ya_re  = '0;
        ya_im  = '0;
        xa     = '0;
        xb     = '0;
        twc    = '0;
        tws    = '0;
        for (int n2 = 0; n2 < 4; n2++) begin
            for (int k1 = 0; k1 < 4; k1++) begin
                ya_re = '0;
                ya_im = '0;
                for (int n1 = 0; n1 < 4; n1++) begin
                    xa = YW'(ibuf_re[s1_bank][4'(n2 + 4 * n1)]);
                    xb = YW'(ibuf_im[s1_bank][4'(n2 + 4 * n1)]);
                    // multiply by (-j)^(n1*k1): swaps and negates only
                    case (2'(n1 * k1))
                        2'd0: begin ya_re = ya_re + xa; ya_im = ya_im + xb; end
                        2'd1: begin ya_re = ya_re + xb; ya_im = ya_im - xa; end
                        2'd2: begin ya_re = ya_re - xa; ya_im = ya_im - xb; end
                        default: begin ya_re = ya_re - xb; ya_im = ya_im + xa; end
                    endcase
                end
                twc = tw_cos(4'(n2 * k1));
                tws = tw_sin(4'(n2 * k1));
                z_re_c[4'(n2 * 4 + k1)] = ZW'(ya_re) * ZW'(twc) + ZW'(ya_im) * ZW'(tws);
                z_im_c[4'(n2 * 4 + k1)] = ZW'(ya_im) * ZW'(twc) - ZW'(ya_re) * ZW'(tws);
            end
        end
    end

    // Stage 2: radix-4 butterfly across n2 per k1, written straight to natural order k1+4*k2.
    always_comb begin
        x_re_c  = '{default: '0};
        x_im_c  = '{default: '0};
        xacc_re = '0;
        xacc_im = '0;
        za      = '0;
        zb      = '0;
        for (int k1 = 0; k1 < 4; k1++) begin
            for (int k2 = 0; k2 < 4; k2++) begin
                xacc_re = '0;
                xacc_im = '0;
                for (int n2 = 0; n2 < 4; n2++) begin
                    za = XW'(z_re[4'(n2 * 4 + k1)]);
                    zb = XW'(z_im[4'(n2 * 4 + k1)]);
                    case (2'(n2 * k2))
                        2'd0: begin xacc_re = xacc_re + za; xacc_im = xacc_im + zb; end
                        2'd1: begin xacc_re = xacc_re + zb; xacc_im = xacc_im - za; end
                        2'd2: begin xacc_re = xacc_re - za; xacc_im = xacc_im - zb; end
                        default: begin xacc_re = xacc_re - zb; xacc_im = xacc_im + za; end
                    endcase
                end
                x_re_c[4'(k1 + 4 * k2)] = OW'(xacc_re >>> 2);
                x_im_c[4'(k1 + 4 * k2)] = OW'(xacc_im >>> 2);
            end
        end
    end

    // Datapath storage: input ping-pong, stage-1 register, output ping-pong.
    always_ff @(posedge sys_clk_i) begin
        if (data_in_valid_i) begin
            ibuf_re[wr_bank][wr_cnt] <= xn_real_i;
            ibuf_im[wr_bank][wr_cnt] <= xn_imag_i;
        end
        if (go1) begin
            z_re <= z_re_c;
            z_im <= z_im_c;
        end
        if (go2) begin
            for (int i = 0; i < 16; i++) begin
                obuf_re[ob_wr][4'(i)] <= x_re_c[4'(i)];
                obuf_im[ob_wr][4'(i)] <= x_im_c[4'(i)];
            end
        end
    end

    // Output streamer: starts a frame on go4, walks X[0..15], zero when idle.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state            <= ST_IDLE;
            rd_bank          <= 1'b0;
            rd_idx           <= '0;
            data_out_valid_o <= 1'b0;
            xk_real_o        <= '0;
            xk_imag_o        <= '0;
        end else if (go4) begin
            state            <= ST_STREAM;
            rd_bank          <= bank4;
            rd_idx           <= IW'(1);
            data_out_valid_o <= 1'b1;
            xk_real_o        <= obuf_re[bank4][0];
            xk_imag_o        <= obuf_im[bank4][0];
        end else if (state == ST_STREAM) begin
            rd_idx           <= rd_idx + 1'b1;
            data_out_valid_o <= 1'b1;
            xk_real_o        <= obuf_re[rd_bank][rd_idx];
            xk_imag_o        <= obuf_im[rd_bank][rd_idx];
            if (rd_idx == IW'(NP - 1)) begin
                state <= ST_IDLE;
            end
        end else begin
            data_out_valid_o <= 1'b0;
            xk_real_o        <= '0;
            xk_imag_o        <= '0;
        end
    end

endmodule

// File: tb/tb_n16_butterfly_base_n4_top.sv
// Scoreboard bench for the 16-point FFT: the driver pushes expected bins with
// their due cycle, a negedge monitor pops and compares every valid output.
module tb_n16_butterfly_base_n4_top;

    localparam int DW = 8;
    localparam int WW = 8;
    localparam int OW = DW + WW + 2;

    logic                 sys_clk_i = 1'b0;
    logic                 rst_n_i;
    logic                 data_in_valid_i;
    logic signed [DW-1:0] xn_real_i;
    logic signed [DW-1:0] xn_imag_i;
    logic                 data_out_valid_o;
    logic signed [OW-1:0] xk_real_o;
    logic signed [OW-1:0] xk_imag_o;

    n16_butterfly_base_n4_top #(
        .DATA_WIDTH (DW),
        .Wn_WIDTH   (WW),
        .N_POINT    (16)
    ) dut (
        .sys_clk_i        (sys_clk_i),
        .rst_n_i          (rst_n_i),
        .data_in_valid_i  (data_in_valid_i),
        .xn_real_i        (xn_real_i),
        .xn_imag_i        (xn_imag_i),
        .data_out_valid_o (data_out_valid_o),
        .xk_real_o        (xk_real_o),
        .xk_imag_o        (xk_imag_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    typedef struct {
        longint re;
        longint im;
        int     cyc;
        int     k;
    } exp_t;

    exp_t   sb_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     n_seen   = 0;
    int     cyc      = 0;
    int     last_edge;
    int     fr_re[16];
    int     fr_im[16];
    longint mdl_re[16];
    longint mdl_im[16];
    longint hand_re[16];
    longint hand_im[16];
    bit     hand_v[16];

    always @(posedge sys_clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic longint rnd(input real v);
        return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
    endfunction

    // Multiply (re + j im) by (-j)^p.
    function automatic longint rot_re(input longint re, input longint im, input int p);
        case (p % 4)
            0: return re;
            1: return im;
            2: return -re;
            default: return -im;
        endcase
    endfunction

    function automatic longint rot_im(input longint re, input longint im, input int p);
        case (p % 4)
            0: return im;
            1: return -re;
            2: return -im;
            default: return re;
        endcase
    endfunction

    // Reference: two radix-4 stages with rounded twiddles, then >>> 2.
    task automatic compute_model();
        longint yr, yi, wr, wi, xr, xi;
        longint zr[16];
        longint zi[16];
        real    ang;
        real    sc;
        sc = 2.0 ** (WW - 2);
        for (int n2 = 0; n2 < 4; n2++) begin
            for (int k1 = 0; k1 < 4; k1++) begin
                yr = 0;
                yi = 0;
                for (int n1 = 0; n1 < 4; n1++) begin
                    yr += rot_re(fr_re[n2 + 4 * n1], fr_im[n2 + 4 * n1], n1 * k1);
                    yi += rot_im(fr_re[n2 + 4 * n1], fr_im[n2 + 4 * n1], n1 * k1);
                end
                ang = 2.0 * 3.14159265358979 * real'(n2 * k1) / 16.0;
                wr  = rnd($cos(ang) * sc);
                wi  = rnd(-$sin(ang) * sc);
                zr[n2 * 4 + k1] = yr * wr - yi * wi;
                zi[n2 * 4 + k1] = yr * wi + yi * wr;
            end
        end
        for (int k1 = 0; k1 < 4; k1++) begin
            for (int k2 = 0; k2 < 4; k2++) begin
                xr = 0;
                xi = 0;
                for (int n2 = 0; n2 < 4; n2++) begin
                    xr += rot_re(zr[n2 * 4 + k1], zi[n2 * 4 + k1], n2 * k2);
                    xi += rot_im(zr[n2 * 4 + k1], zi[n2 * 4 + k1], n2 * k2);
                end
                mdl_re[k1 + 4 * k2] = xr >>> 2;
                mdl_im[k1 + 4 * k2] = xi >>> 2;
            end
        end
    endtask

    task automatic set_hand(input int k, input longint re, input longint im);
        hand_re[k] = re;
        hand_im[k] = im;
        hand_v[k]  = 1'b1;
    endtask

    // Queue the 16 expected bins of the frame whose last sample hit edge t.
    task automatic push_frame(input int t);
        exp_t e;
        compute_model();
        for (int k = 0; k < 16; k++) begin
            e.re  = hand_v[k] ? hand_re[k] : mdl_re[k];
            e.im  = hand_v[k] ? hand_im[k] : mdl_im[k];
            e.cyc = t + 4 + k;
            e.k   = k;
            sb_q.push_back(e);
            hand_v[k] = 1'b0;
        end
    endtask

    task automatic send_sample(input int re, input int im);
        @(negedge sys_clk_i);
        data_in_valid_i = 1'b1;
        xn_real_i       = DW'(re);
        xn_imag_i       = DW'(im);
        @(posedge sys_clk_i);
        #1;
        data_in_valid_i = 1'b0;
        last_edge       = cyc;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int n = lo; n <= hi; n++) send_sample(fr_re[n], fr_im[n]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clk_i);
            data_in_valid_i = 1'b0;
            xn_real_i       = DW'($urandom);
            xn_imag_i       = DW'($urandom);
        end
    endtask

    // Monitor: every valid output must match the head of the scoreboard on time.
    always @(negedge sys_clk_i) begin
        exp_t e;
        if (data_out_valid_o) begin
            n_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("bin%0d_re", e.k), longint'(xk_real_o), e.re);
                check($sformatf("bin%0d_im", e.k), longint'(xk_imag_o), e.im);
                check($sformatf("bin%0d_cycle", e.k), longint'(cyc), longint'(e.cyc));
            end
        end else begin
            check("idle_re_zero", longint'(xk_real_o), 0);
            check("idle_im_zero", longint'(xk_imag_o), 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int base;
        bit hit;
        rst_n_i         = 1'b0;
        data_in_valid_i = 1'b0;
        xn_real_i       = '0;
        xn_imag_i       = '0;
        for (int k = 0; k < 16; k++) hand_v[k] = 1'b0;

        // 1: reset held with random traffic
        repeat (20) begin
            @(negedge sys_clk_i);
            data_in_valid_i = 1'($urandom_range(0, 1));
            xn_real_i       = DW'($urandom);
            xn_imag_i       = DW'($urandom);
        end
        @(negedge sys_clk_i);
        data_in_valid_i = 1'b0;
        rst_n_i         = 1'b1;
        #1;
        check("reset_valid", longint'(data_out_valid_o), 0);
        check("reset_re", longint'(xk_real_o), 0);
        idle(3);

        // 2 and 3: two frames back to back
        for (int n = 0; n < 16; n++) begin
            fr_re[n] = 2 * n + 1;
            fr_im[n] = 31 - 2 * n;
        end
        send_range(0, 15);
        set_hand(0, 4096, 4096);
        set_hand(4, 0, 512);
        set_hand(8, -256, 256);
        set_hand(12, -512, 0);
        push_frame(last_edge);
        for (int n = 0; n < 16; n++) begin
            fr_re[n] = 33 + 2 * n;
            fr_im[n] = -(2 * n + 1);
        end
        send_range(0, 15);
        set_hand(0, 12288, -4096);
        set_hand(4, 0, 512);
        set_hand(8, -256, 256);
        set_hand(12, -512, 0);
        push_frame(last_edge);
        idle(30);

        // 4: impulse
        for (int n = 0; n < 16; n++) begin
            fr_re[n] = (n == 0) ? 127 : 0;
            fr_im[n] = 0;
        end
        send_range(0, 15);
        for (int k = 0; k < 16; k++) set_hand(k, 2032, 0);
        push_frame(last_edge);
        idle(30);

        // 5: frame split by a 20-cycle gap
        for (int n = 0; n < 16; n++) begin
            fr_re[n] = 5 * n - 40;
            fr_im[n] = 7 - 3 * n;
        end
        send_range(0, 9);
        idle(20);
        send_range(10, 15);
        push_frame(last_edge);
        idle(30);

        // 6: reset after 8 bins, with a partial next frame in flight
        for (int n = 0; n < 16; n++) begin
            fr_re[n] = 10 * n - 75;
            fr_im[n] = 60 - 8 * n;
        end
        base = n_seen;
        send_range(0, 15);
        push_frame(last_edge);
        repeat (5) send_sample(100, -100);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge sys_clk_i);
            #2;
            if (n_seen >= base + 8) hit = 1'b1;
        end
        check("reach_8_bins", longint'(hit), 1);
        rst_n_i = 1'b0;
        sb_q.delete();
        #1;
        check("midreset_valid", longint'(data_out_valid_o), 0);
        check("midreset_re", longint'(xk_real_o), 0);
        check("midreset_im", longint'(xk_imag_o), 0);
        idle(3);
        @(negedge sys_clk_i);
        rst_n_i = 1'b1;
        idle(40);

        // after reset the counter restarts at n=0
        for (int n = 0; n < 16; n++) begin
            fr_re[n] = (n == 0) ? 127 : 0;
            fr_im[n] = 0;
        end
        send_range(0, 15);
        for (int k = 0; k < 16; k++) set_hand(k, 2032, 0);
        push_frame(last_edge);
        idle(30);

        check("scoreboard_drained", longint'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
